// File: rtl/hyper_ram_responder_pkg.sv
// Shared types and constants for the HyperBus memory responder.
//   state_e     : responder FSM states
//   CA_*        : bit positions inside the 48-bit command/address word
//   WRAP_WORDS  : size of the aligned group used by wrapped bursts
package hyper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    RDATA,
    WDATA,
    REGW
  } state_e;

  localparam int CA_RW     = 47;
  localparam int CA_AS     = 46;
  localparam int CA_BT     = 45;
  localparam int CA_ROW_HI = 44;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;

  localparam int CA_BYTES   = 6;
  localparam int WRAP_WORDS = 16;

endpackage

// File: rtl/hyper_ram_responder_mem.sv
// Word-wide backing store for the responder.
//   clk_i   : clock
//   we_i    : write strobe
//   be_i    : byte enables, [1] = bits 15:8, [0] = bits 7:0
//   addr_i  : word address shared by the write and read ports
//   wdata_i : write data
//   rdata_o : asynchronous read data at addr_i
module hyper_resp_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [MEM_WORDS];

  // No reset: contents survive both the system and the device reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hyper_ram_responder.sv
// HyperBus device-side memory responder, oversampling CK in the sys_clk_i
// domain. Decodes the command/address, applies fixed 2x initial latency and
// serves linear or wrapped word bursts from hyper_resp_mem, or the ID value
// for register-space reads.
//   sys_clk_i, rstn_i          : clock, async active-low reset
//   hyper_reset_ni             : device reset (memory kept)
//   hyper_cs_ni, hyper_ck_i    : chip select and bus clock
//   hyper_dq_i/_o/_oe_o        : data bus
//   hyper_rwds_i/_o/_oe_o      : write mask in, read strobe / latency out
//   busy_o                     : any state other than IDLE
//
// state | meaning
// IDLE  | waiting for chip select to fall
// CA    | shifting in the six command/address bytes
// LAT   | initial latency, 4*LAT_CYC edges
// RDATA | presenting read bytes, upper then lower
// WDATA | collecting write bytes, committing on the lower byte
// REGW  | swallowing the two register-write bytes
module hyper_ram_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LAT_CYC   = 6,
  parameter logic [15:0] ID_REG    = 16'h0C81
) (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       hyper_reset_ni,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  input  logic       hyper_rwds_i,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o,
  output logic       busy_o
);
  import hyper_pkg::*;

  localparam int AW        = $clog2(MEM_WORDS);
  localparam int WW        = $clog2(WRAP_WORDS);
  localparam int LAT_EDGES = 4 * LAT_CYC;
  localparam int CW        = $clog2(LAT_EDGES);
  localparam int RW        = AW - CA_COL_HI - 1;
  localparam int HDR_LSB   = 8 * (CA_BYTES - 1);

  state_e          state_q;
  logic            ck_q, cs_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   addr_q;
  logic            rd_q, as_q, wrap_q, half_q;
  logic [7:0]      wup_q;
  logic            wup_mask_q;
  logic [7:0]      dq_q;
  logic            dq_oe_q, rwds_q, rwds_oe_q;

  logic            ck_edge;
  logic [AW-1:0]   addr_inc;
  logic [15:0]     mem_rdata, rd_word;
  logic            mem_we;

  // cs high suppresses the edge, so a cs rise coinciding with CK moves no byte.
  assign ck_edge = (ck_q ^ hyper_ck_i) & ~hyper_cs_ni & hyper_reset_ni;
  assign rd_word = as_q ? ID_REG : mem_rdata;
  assign mem_we  = (state_q == WDATA) & ck_edge & half_q;

  always_comb begin
    addr_inc = addr_q + AW'(1);
    if (wrap_q) addr_inc = {addr_q[AW-1:WW], addr_q[WW-1:0] + WW'(1)};
  end

  hyper_resp_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk_i   (sys_clk_i),
    .we_i    (mem_we),
    .be_i    ({~wup_mask_q, ~hyper_rwds_i}),
    .addr_i  (addr_q),
    .wdata_i ({wup_q, hyper_dq_i}),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ck_q       <= 1'b0;
      cs_q       <= 1'b0;  // a cs already low at reset release does not start a burst
      cnt_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      as_q       <= 1'b0;
      wrap_q     <= 1'b0;
      half_q     <= 1'b0;
      wup_q      <= '0;
      wup_mask_q <= 1'b0;
      dq_q       <= '0;
      dq_oe_q    <= 1'b0;
      rwds_q     <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      ck_q <= hyper_ck_i;
      cs_q <= hyper_cs_ni;
      if (hyper_cs_ni || !hyper_reset_ni) begin
        state_q   <= IDLE;
        dq_q      <= '0;
        dq_oe_q   <= 1'b0;
        rwds_q    <= 1'b0;
        rwds_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_q) begin
              state_q   <= CA;
              cnt_q     <= CW'(CA_BYTES - 1);
              rwds_oe_q <= 1'b1;
              rwds_q    <= 1'b1;
            end
          end
          CA: begin
            if (ck_edge) begin
              if (cnt_q == CW'(CA_BYTES - 1)) begin
                rd_q   <= hyper_dq_i[CA_RW - HDR_LSB];
                as_q   <= hyper_dq_i[CA_AS - HDR_LSB];
                wrap_q <= ~hyper_dq_i[CA_BT - HDR_LSB];
              end
              // Row bits stop shifting at the byte holding CA_ROW_LO, so the
              // register ends up with the low row bits that index the memory.
              if (cnt_q >= CW'(CA_ROW_LO / 8)) row_q <= RW'({row_q, hyper_dq_i});
              if (cnt_q == '0) begin
                addr_q <= {row_q, hyper_dq_i[CA_COL_HI:0]};
                if (as_q && !rd_q) begin
                  state_q   <= REGW;
                  cnt_q     <= CW'(1);
                  rwds_oe_q <= 1'b0;
                  rwds_q    <= 1'b0;
                end else begin
                  state_q   <= LAT;
                  cnt_q     <= CW'(LAT_EDGES - 1);
                  rwds_oe_q <= rd_q;
                  rwds_q    <= 1'b0;
                end
              end else begin
                cnt_q <= cnt_q - CW'(1);
              end
            end
          end
          LAT: begin
            if (ck_edge) begin
              if (cnt_q == '0) begin
                half_q <= 1'b0;
                if (rd_q) begin
                  state_q   <= RDATA;
                  dq_q      <= rd_word[15:8];
                  dq_oe_q   <= 1'b1;
                  rwds_q    <= 1'b1;
                  rwds_oe_q <= 1'b1;
                end else begin
                  state_q <= WDATA;
                end
              end else begin
                cnt_q <= cnt_q - CW'(1);
              end
            end
          end
          RDATA: begin
            // Advancing while the lower byte is out lets the next word settle
            // through the asynchronous read before its upper byte is needed.
            if (ck_edge) begin
              half_q <= ~half_q;
              if (!half_q) begin
                dq_q   <= rd_word[7:0];
                rwds_q <= 1'b0;
                addr_q <= addr_inc;
              end else begin
                dq_q   <= rd_word[15:8];
                rwds_q <= 1'b1;
              end
            end
          end
          WDATA: begin
            if (ck_edge) begin
              half_q <= ~half_q;
              if (!half_q) begin
                wup_q      <= hyper_dq_i;
                wup_mask_q <= hyper_rwds_i;
              end else begin
                addr_q <= addr_inc;
              end
            end
          end
          REGW: begin
            if (ck_edge) begin
              if (cnt_q == '0) state_q <= IDLE;
              else             cnt_q   <= cnt_q - CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hyper_dq_o      = dq_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_hyper_ram_responder.sv
module tb_hyper_ram_responder;

  localparam int          MW  = 1024;
  localparam int          LAT = 6;
  localparam int          LE  = 4 * LAT;
  localparam logic [15:0] ID  = 16'h0C81;

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic       hrst_n  = 1'b1;
  logic       cs_n    = 1'b1;
  logic       ck      = 1'b0;
  logic [7:0] dq_in   = 8'h00;
  logic       rwds_in = 1'b0;
  logic [7:0] dq_out;
  logic       dq_oe, rwds_out, rwds_oe, busy;

  always #5 sys_clk = ~sys_clk;

  hyper_ram_responder #(.MEM_WORDS(MW), .LAT_CYC(LAT), .ID_REG(ID)) dut (
    .sys_clk_i       (sys_clk),
    .rstn_i          (rstn),
    .hyper_reset_ni  (hrst_n),
    .hyper_cs_ni     (cs_n),
    .hyper_ck_i      (ck),
    .hyper_dq_i      (dq_in),
    .hyper_dq_o      (dq_out),
    .hyper_dq_oe_o   (dq_oe),
    .hyper_rwds_i    (rwds_in),
    .hyper_rwds_o    (rwds_out),
    .hyper_rwds_oe_o (rwds_oe),
    .busy_o          (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mem_m [MW];
  logic [15:0] wbuf  [MW];
  logic [1:0]  mbuf  [MW];
  logic [15:0] ebuf  [16];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic as, input logic lin, input int a);
    logic [47:0] c;
    logic [31:0] w;
    c = '0;
    w = a;
    c[47] = rd;
    c[46] = as;
    c[45] = lin;
    c[44:16] = w[31:3];
    c[2:0] = w[2:0];
    return c;
  endfunction

  function automatic int seq_addr(input logic lin, input int a, input int i);
    if (lin) return (a + i) % MW;
    return (a / 16) * 16 + (a + i) % 16;
  endfunction

  task automatic ck_pulse(input logic [7:0] d, input logic m);
    @(negedge sys_clk);
    dq_in = d;
    rwds_in = m;
    ck = ~ck;
    @(negedge sys_clk);
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    cs_n = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic cs_high();
    @(negedge sys_clk);
    cs_n = 1'b1;
    @(negedge sys_clk);
    check_val("cs_idle", {busy, dq_oe, rwds_oe}, 3'b000);
  endtask

  task automatic send_ca(input logic [47:0] ca);
    cs_low();
    for (int i = 0; i < 6; i++) begin
      ck_pulse(ca[47-8*i -: 8], 1'b0);
      if (i == 0) check_val("ca_rwds", {busy, rwds_oe, rwds_out}, 3'b111);
    end
  endtask

  task automatic lat(input logic rd);
    for (int i = 0; i < LE; i++) begin
      ck_pulse(8'($urandom), 1'b0);
      if (i == 0) begin
        if (rd) check_val("lat_rd", {rwds_oe, rwds_out}, 2'b10);
        else    check_val("lat_wr", {31'd0, rwds_oe}, 32'd0);
      end
    end
  endtask

  task automatic do_read(input logic [47:0] ca, input int n);
    send_ca(ca);
    lat(1'b1);
    for (int i = 0; i < n; i++) begin
      check_val("rd_hi", {dq_oe, rwds_out, dq_out}, {1'b1, 1'b1, ebuf[i][15:8]});
      ck_pulse(8'($urandom), 1'b0);
      check_val("rd_lo", {dq_oe, rwds_out, dq_out}, {1'b1, 1'b0, ebuf[i][7:0]});
      ck_pulse(8'($urandom), 1'b0);
    end
    cs_high();
  endtask

  task automatic do_write(input logic [47:0] ca, input int n);
    send_ca(ca);
    lat(1'b0);
    for (int i = 0; i < n; i++) begin
      ck_pulse(wbuf[i][15:8], mbuf[i][1]);
      ck_pulse(wbuf[i][7:0], mbuf[i][0]);
    end
    cs_high();
  endtask

  task automatic model_write(input logic lin, input int a, input int n);
    int x;
    for (int i = 0; i < n; i++) begin
      x = seq_addr(lin, a, i);
      if (!mbuf[i][1]) mem_m[x][15:8] = wbuf[i][15:8];
      if (!mbuf[i][0]) mem_m[x][7:0]  = wbuf[i][7:0];
    end
  endtask

  task automatic wr(input logic lin, input int a, input int n);
    do_write(mk_ca(1'b0, 1'b0, lin, a), n);
    model_write(lin, a, n);
  endtask

  task automatic rd(input logic lin, input int a, input int n);
    for (int i = 0; i < n; i++) ebuf[i] = mem_m[seq_addr(lin, a, i)];
    do_read(mk_ca(1'b1, 1'b0, lin, a), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached without finish", $time);
    $fatal(1);
  end

  initial begin
    int a, n, kind;
    logic lin;

    repeat (3) @(negedge sys_clk);
    check_val("reset", {busy, dq_oe, rwds_oe, rwds_out, dq_out}, 12'h000);
    rstn = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_val("reset_idle", {busy, dq_oe, rwds_oe, rwds_out, dq_out}, 12'h000);

    // register read
    ebuf[0] = 16'h0C81;
    do_read(48'hC000_0000_0000, 1);

    // fill whole memory with known random data
    for (int i = 0; i < MW; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    wr(1'b1, 0, MW);

    // linear write / read
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    for (int i = 0; i < 4; i++) mbuf[i] = 2'b00;
    wr(1'b1, 'h10, 4);
    ebuf[0] = 16'h1111; ebuf[1] = 16'h2222; ebuf[2] = 16'h3333; ebuf[3] = 16'h4444;
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 'h10), 4);

    // masked write over existing data
    wbuf[0] = 16'h5555;
    wr(1'b1, 'h20, 1);
    wbuf[0] = 16'hABCD; mbuf[0] = 2'b01;
    wr(1'b1, 'h20, 1);
    mbuf[0] = 2'b00;
    ebuf[0] = 16'hAB55;
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 'h20), 1);

    // wrapped versus linear
    for (int i = 0; i < 18; i++) begin
      wbuf[i] = 16'(16'h10 + i);
      mbuf[i] = 2'b00;
    end
    wr(1'b1, 'h10, 18);
    ebuf[0] = 16'h001E; ebuf[1] = 16'h001F; ebuf[2] = 16'h0010; ebuf[3] = 16'h0011;
    do_read(mk_ca(1'b1, 1'b0, 1'b0, 'h1E), 4);
    ebuf[2] = 16'h0020; ebuf[3] = 16'h0021;
    do_read(mk_ca(1'b1, 1'b0, 1'b1, 'h1E), 4);

    // linear wrap at the top of memory
    wbuf[0] = 16'hBEEF; wbuf[1] = 16'hCAFE;
    wr(1'b1, MW - 1, 2);
    ebuf[0] = 16'hBEEF; ebuf[1] = 16'hCAFE;
    do_read(mk_ca(1'b1, 1'b0, 1'b1, MW - 1), 2);

    // cs abort during CA, then clean register read
    cs_low();
    ck_pulse(8'hC0, 1'b0);
    ck_pulse(8'h00, 1'b0);
    ck_pulse(8'h00, 1'b0);
    cs_high();
    ebuf[0] = 16'h0C81;
    do_read(48'hC000_0000_0000, 1);

    // register write swallows two bytes and leaves memory alone
    send_ca(mk_ca(1'b0, 1'b1, 1'b0, 0));
    ck_pulse(8'h12, 1'b0);
    ck_pulse(8'h34, 1'b0);
    cs_high();
    rd(1'b1, 0, 2);

    // cs rise after the upper write byte
    send_ca(mk_ca(1'b0, 1'b0, 1'b1, 'h30));
    lat(1'b0);
    ck_pulse(8'h77, 1'b0);
    cs_high();
    rd(1'b1, 'h30, 1);

    // cs rise together with the lower-byte edge
    send_ca(mk_ca(1'b0, 1'b0, 1'b1, 'h31));
    lat(1'b0);
    ck_pulse(8'h66, 1'b0);
    @(negedge sys_clk);
    cs_n = 1'b1;
    ck = ~ck;
    dq_in = 8'h99;
    @(negedge sys_clk);
    check_val("cs_ck_tie", {busy, dq_oe, rwds_oe}, 3'b000);
    rd(1'b1, 'h31, 1);

    // system reset in the middle of a read
    send_ca(mk_ca(1'b1, 1'b0, 1'b1, 'h10));
    lat(1'b1);
    ck_pulse(8'h00, 1'b0);
    @(negedge sys_clk);
    rstn = 1'b0;
    #1;
    check_val("rst_mid", {busy, dq_oe, rwds_oe, rwds_out, dq_out}, 12'h000);
    @(negedge sys_clk);
    rstn = 1'b1;
    cs_high();
    rd(1'b1, 'h10, 4);

    // device reset in the middle of a write: first word kept, second dropped
    wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
    send_ca(mk_ca(1'b0, 1'b0, 1'b1, 'h40));
    lat(1'b0);
    ck_pulse(wbuf[0][15:8], 1'b0);
    ck_pulse(wbuf[0][7:0], 1'b0);
    ck_pulse(wbuf[1][15:8], 1'b0);
    @(negedge sys_clk);
    hrst_n = 1'b0;
    @(negedge sys_clk);
    check_val("hrst_mid", {busy, dq_oe, rwds_oe}, 3'b000);
    ck_pulse(wbuf[1][7:0], 1'b0);
    hrst_n = 1'b1;
    cs_high();
    mem_m['h40] = wbuf[0];
    rd(1'b1, 'h40, 2);

    // random traffic against the model
    for (int t = 0; t < 30; t++) begin
      a    = $urandom_range(MW - 1, 0);
      n    = $urandom_range(8, 1);
      lin  = 1'($urandom);
      kind = $urandom_range(4, 0);
      if (kind < 2) begin
        for (int i = 0; i < n; i++) begin
          wbuf[i] = 16'($urandom);
          mbuf[i] = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
        end
        wr(lin, a, n);
      end else if (kind < 4) begin
        rd(lin, a, n);
      end else begin
        for (int i = 0; i < n; i++) ebuf[i] = ID;
        do_read(mk_ca(1'b1, 1'b1, lin, a), n);
      end
    end
    for (int i = 0; i < 8; i++) rd(1'b1, $urandom_range(MW - 1, 0), 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hyper_ram_responder.md
# hyper_ram_responder

Synthesizable HyperBus memory responder (device side) for on-chip loopback and bench use against the udma HyperBus controller. It sits at the pad-side signal level, runs in the sys_clk_i domain, and oversamples CK to detect edges. It decodes the 48-bit command/address, inserts fixed 2x initial latency, and serves linear or wrapped 16-bit-word bursts from an internal byte-enabled memory. It also serves a read-only ID register space.

## Interface
- MEM_WORDS, 1024: memory depth in 16-bit words; power of two.
- LAT_CYC, 6: initial latency in CK cycles; doubled, since RWDS signals 2x latency.
- ID_REG, 16'h0C81: value returned for every register-space read.
- sys_clk_i  in  1  system clock; must be ≥4x CK frequency.
- rstn_i  in  1  reset, asynchronous, active-low.
- hyper_reset_ni  in  1  device reset, sampled; low forces IDLE, same effect as rstn_i except memory contents are kept.
- hyper_cs_ni  in  1  chip select, active-low.
- hyper_ck_i  in  1  bus clock, synchronous to sys_clk_i from the bench/pad.
- hyper_dq_i  in  8  DQ from controller.
- hyper_dq_o  out  8  DQ to controller; reset 8'h00.
- hyper_dq_oe_o  out  1  DQ drive enable; reset 0.
- hyper_rwds_i  in  1  write byte mask, 1 = byte masked.
- hyper_rwds_o  out  1  RWDS driven value; reset 0.
- hyper_rwds_oe_o  out  1  RWDS drive enable; reset 0.
- busy_o  out  1  high in any state but IDLE; reset 0.

## Operation
- Edge detect: ck_q <= hyper_ck_i every cycle; edge = ck_q ^ hyper_ck_i while cs low. Every CK edge (rise or fall) carries one byte.
- States:
  - IDLE -> CA on cs falling.
  - CA: shifts 6 bytes MSB-first into ca[47:0]. Drives rwds_oe=1, rwds_o=1 (2x latency).
  - After the 6th edge:
    - ca[46]=1 and ca[47]=0 (register write): -> REGW. Takes 2 data bytes with zero latency; the bytes are discarded.
    - Otherwise: -> LAT.
  - LAT: counts 4*LAT_CYC edges.
    - Read: rwds_oe=1, rwds_o=0.
    - Write: rwds_oe=0.
    - Then -> RDATA or WDATA.
  - RDATA: dq_oe=1.
    - Even byte = word[15:8], odd byte = word[7:0].
    - rwds_o toggles with each byte presented: 1 for upper, 0 for lower.
    - Address advances after the lower byte.
    - Register space: returns ID_REG for any address.
  - WDATA: samples dq_i/rwds_i on each edge.
    - Upper byte is held.
    - The lower-byte edge commits the word with be = {~rwds_upper, ~rwds_lower}.
    - Address advances.
- Address: word addr = {ca[44:16], ca[2:0]} mod MEM_WORDS.
  - Linear (ca[45]=1): increments and wraps at MEM_WORDS-1 -> 0.
  - Wrapped (ca[45]=0): increments within the aligned 16-word group, {addr[hi:4], addr[3:0]+1}.
- cs rising in any state -> IDLE next cycle. All oe drop; a half-written word (upper byte only) is discarded.
- Simultaneous cs rise and CK edge: cs wins and no byte is processed.
- rstn_i or hyper_reset_ni low mid-burst: -> IDLE, outputs at reset values. Memory is not cleared on hyper_reset_ni.

## Timing
- Edge seen in cycle t (ck_q != ck_i): state/counters update at t+1.
- RDATA outputs (dq_o, rwds_o) change at t+1.
  - First read byte appears 1 sys_clk after the last LAT edge.
  - Each following byte appears 1 sys_clk after each subsequent edge.
- Write commit reaches memory 1 cycle after the lower-byte edge; a read of the same word in a later transaction returns the new data.
- Memory read is asynchronous or prefetched so that the upper byte is valid at t+1. The next word is fetched during the lower byte.
- Edge counts: CA = 6 edges, LAT = 4*LAT_CYC edges (24 by default), data = 2 edges per word.

## Structure
- Shared package hyper_pkg:
  - state enum {IDLE, CA, LAT, RDATA, WDATA, REGW}.
  - CA field positions: CA_RW=47, CA_AS=46, CA_BT=45, CA_ROW_HI=44, CA_ROW_LO=16, CA_COL_HI=2.
  - WRAP_WORDS=16.
- Sub-module hyper_resp_mem: MEM_WORDS x 16 array, one write port with 2-bit byte enable, one asynchronous read port.
- Top holds the edge detector, FSM, edge counter, address generator and output registers.

## Test plan
- Register read: CA 48'hC000_0000_0000, 24 latency edges -> bytes 8'h0C, 8'h81 with rwds_o 1,0; dq_oe_o falls 1 cycle after cs rise.
- Linear write of 16'h1111, 16'h2222, 16'h3333, 16'h4444 at word 0x10, then linear read of 4 words at 0x10 -> identical data, busy_o low between transactions.
- Masked write 16'hABCD at 0x20, with rwds_i=1 on the lower byte over existing 16'h5555 -> readback 16'hAB55.
- Wrapped read of 4 words starting at word 0x1E, with 0x10..0x1F preloaded with their index -> 0x1E, 0x1F, 0x10, 0x11. The same linear read returns 0x1E, 0x1F, 0x20, 0x21. A linear read from MEM_WORDS-1 wraps to 0.
- cs rises after 3 CA edges, then a full register read follows -> the second transaction returns 16'h0C81 with no residue. cs rises after an upper write byte -> target word unchanged.
- rstn_i pulsed low during RDATA -> outputs 0 within the assertion; the next read transaction completes normally and memory is intact.
